// File: rtl/geofence_pkg.sv
// Shared types and width helpers for the geofence point-in-convex-polygon block.
package geofence_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed cross-product width: two (CW+1)-bit differences multiply into 2CW+2 bits.
  // One more bit keeps the difference of two such products exact.
  function automatic int cross_w(input int cw);
    return 2 * cw + 3;
  endfunction

  // Counter width large enough to hold 0..NV.
  function automatic int cnt_w(input int nv);
    return $clog2(nv + 1);
  endfunction

endpackage

// File: rtl/geofence_cross.sv
// Combinational signed cross product (B-A) x (C-A) of three unsigned points.
module geofence_cross
  import geofence_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic [CW-1:0]                 ax,
  input  logic [CW-1:0]                 ay,
  input  logic [CW-1:0]                 bx,
  input  logic [CW-1:0]                 by,
  input  logic [CW-1:0]                 cx,
  input  logic [CW-1:0]                 cy,
  output logic signed [cross_w(CW)-1:0] cr
);
  localparam int XW = cross_w(CW);
  localparam int EW = XW - CW - 1;

  logic signed [CW:0]   dbx, dby, dcx, dcy;
  logic signed [XW-1:0] p1, p2;

  // Zero-extend, subtract, sign-extend to full width; low XW bits of the product are exact.
  always_comb begin
    dbx = $signed({1'b0, bx}) - $signed({1'b0, ax});
    dby = $signed({1'b0, by}) - $signed({1'b0, ay});
    dcx = $signed({1'b0, cx}) - $signed({1'b0, ax});
    dcy = $signed({1'b0, cy}) - $signed({1'b0, ay});
    p1  = {{EW{dbx[CW]}}, dbx} * {{EW{dcy[CW]}}, dcy};
    p2  = {{EW{dcx[CW]}}, dcx} * {{EW{dby[CW]}}, dby};
    cr  = p1 - p2;
  end

endmodule

// File: rtl/geofence_nv.sv
// Point-in-convex-polygon tester: loads P and NV vertices, sorts the vertices CCW
// about V1, then checks P against every edge with one shared cross-product unit.
module geofence_nv
  import geofence_pkg::*;
#(
  parameter int NV = 6,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  output logic          out_valid,
  output logic          is_inside,
  output logic          on_edge,
  output logic          busy
);
  localparam int XW = cross_w(CW);
  localparam int NW = cnt_w(NV);
  localparam logic [NW-1:0] NV_C   = NW'(NV);
  localparam logic [NW-1:0] P_LAST = NW'(NV - 2);
  localparam logic [NW-1:0] K_LAST = NW'(NV - 1);
  localparam logic [NW-1:0] ONE    = NW'(1);
  localparam logic [NW-1:0] TWO    = NW'(2);

  generate
    if (NV < 3 || NV > 15) begin : g_bad_nv
      $error("geofence_nv: NV must be in 3..15");
    end
  endgenerate

  state_t state_q, state_d;
  logic [NW-1:0] ld_cnt, pass, j, k;
  logic          neg, zero;
  logic [NV-1:0][CW-1:0] vx, vy;
  logic [CW-1:0] px, py;
  logic [NW-1:0] ib, ic;
  logic [CW-1:0] ax, ay, bx, by, cx, cy;
  logic signed [XW-1:0] cr;
  logic acc, last_ld, pass_end, sort_last, chk_last;

  assign in_ready  = (state_q == LOAD);
  assign busy      = !in_ready;
  assign acc       = in_valid && in_ready;
  assign last_ld   = acc && (ld_cnt == NV_C);
  assign pass_end  = (j == NV_C - pass);
  assign sort_last = pass_end && (pass == P_LAST);
  assign chk_last  = (k == K_LAST);

  // Operand mux: SORT compares (V1, Vj, Vj+1), CHECK tests (P, Vk, Vk+1) with wrap to V1.
  always_comb begin
    ib = j - ONE;
    ic = j;
    ax = vx[0];
    ay = vy[0];
    if (state_q == CHECK) begin
      ib = k;
      ic = chk_last ? '0 : k + ONE;
      ax = px;
      ay = py;
    end
    bx = vx[ib];
    by = vy[ib];
    cx = vx[ic];
    cy = vy[ic];
  end

  geofence_cross #(.CW(CW)) u_cross (
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy), .cr(cr)
  );

  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;

  // Next state: fixed-length phases, no early exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (last_ld) state_d = SORT;
      SORT:    if (sort_last) state_d = CHECK;
      CHECK:   if (chk_last) state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  // Counters, edge-sign flags and the registered result.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ld_cnt    <= '0;
      pass      <= '0;
      j         <= '0;
      k         <= '0;
      neg       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      is_inside <= 1'b0;
      on_edge   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        LOAD: if (acc) begin
          ld_cnt <= last_ld ? '0 : ld_cnt + ONE;
          if (last_ld) begin
            pass <= ONE;
            j    <= TWO;
            k    <= '0;
            neg  <= 1'b0;
            zero <= 1'b0;
          end
        end
        SORT: begin
          if (pass_end) begin
            pass <= pass + ONE;
            j    <= TWO;
          end else begin
            j <= j + ONE;
          end
        end
        CHECK: begin
          k <= k + ONE;
          if (cr < 0)  neg  <= 1'b1;
          if (cr == 0) zero <= 1'b1;
        end
        default: begin
          out_valid <= 1'b1;
          is_inside <= !neg && !zero;
          on_edge   <= !neg && zero;
        end
      endcase
    end

  // Point storage: P and vertices on load, adjacent swap during SORT when the turn is clockwise.
  always_ff @(posedge clk)
    if (acc) begin
      if (ld_cnt == '0) begin
        px <= X;
        py <= Y;
      end else begin
        vx[ld_cnt - ONE] <= X;
        vy[ld_cnt - ONE] <= Y;
      end
    end else if (state_q == SORT && cr < 0) begin
      vx[j - ONE] <= vx[j];
      vy[j - ONE] <= vy[j];
      vx[j]       <= vx[j - ONE];
      vy[j]       <= vy[j - ONE];
    end

endmodule
